// File: rtl/memory_access_unit_if.sv
// ---------------------------------------------------------------------------
// memory_access_unit_if
//
// Groups every bus of the dual-lane memory stage into one interface:
//   - execute-side bundle: inValid, aluResult1/2, storeData1/2, isLd1/2,
//     isSt1/2, isWb1/2, rd1/2, isBranchTaken1/2, branchPC1/2, and the stall
//     returned upstream
//   - data-memory port: memReq, memWe, memAddr, memWdata, memRdata, memAck
//   - writeback bundle: wbValid, wbEn1/2, wbRd1/2, wbData1/2
//   - fetch redirect: redirect, redirectPC
//   - timeout error flag: memErr
//
// Modports:
//   slave  - the memory access unit itself
//   master - the surroundings (execute stage, data memory, writeback, fetch)
// ---------------------------------------------------------------------------
interface memory_access_unit_if #(
    parameter int ADDR_W = 32
) ();
    // execute -> memory stage
    logic              inValid;
    logic [31:0]       aluResult1;
    logic [31:0]       aluResult2;
    logic [31:0]       storeData1;
    logic [31:0]       storeData2;
    logic              isLd1;
    logic              isLd2;
    logic              isSt1;
    logic              isSt2;
    logic              isWb1;
    logic              isWb2;
    logic [3:0]        rd1;
    logic [3:0]        rd2;
    logic              isBranchTaken1;
    logic              isBranchTaken2;
    logic [31:0]       branchPC1;
    logic [31:0]       branchPC2;
    logic              stall;

    // data-memory port
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [31:0]       memRdata;
    logic              memAck;

    // writeback bundle
    logic              wbValid;
    logic              wbEn1;
    logic              wbEn2;
    logic [3:0]        wbRd1;
    logic [3:0]        wbRd2;
    logic [31:0]       wbData1;
    logic [31:0]       wbData2;

    // fetch redirect and error flag
    logic              redirect;
    logic [31:0]       redirectPC;
    logic              memErr;

    modport slave (
        input  inValid, aluResult1, aluResult2, storeData1, storeData2,
               isLd1, isLd2, isSt1, isSt2, isWb1, isWb2, rd1, rd2,
               isBranchTaken1, isBranchTaken2, branchPC1, branchPC2,
               memRdata, memAck,
        output stall, memReq, memWe, memAddr, memWdata,
               wbValid, wbEn1, wbEn2, wbRd1, wbRd2, wbData1, wbData2,
               redirect, redirectPC, memErr
    );

    modport master (
        output inValid, aluResult1, aluResult2, storeData1, storeData2,
               isLd1, isLd2, isSt1, isSt2, isWb1, isWb2, rd1, rd2,
               isBranchTaken1, isBranchTaken2, branchPC1, branchPC2,
               memRdata, memAck,
        input  stall, memReq, memWe, memAddr, memWdata,
               wbValid, wbEn1, wbEn2, wbRd1, wbRd2, wbData1, wbData2,
               redirect, redirectPC, memErr
    );
endinterface

// File: rtl/memory_access_unit.sv
// ---------------------------------------------------------------------------
// memory_access_unit
//
// Dual-lane memory stage behind the dual-issue execute unit. A two-instruction
// bundle is accepted whenever the unit is not busy with memory traffic; the
// bundle's loads/stores are then issued one at a time over a single req/ack
// data-memory port (lane 1 first), and once all of them have completed the
// unit presents a one-cycle writeback bundle. A taken branch in the accepted
// bundle produces a registered one-cycle fetch redirect; a taken branch in
// lane 1 squashes lane 2.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous reset, active-high
//   bus  - memory_access_unit_if.slave: execute bundle in + stall out,
//          data-memory req/ack port, writeback bundle, redirect, memErr
//
// Parameters:
//   ADDR_W  - data-memory address width (low bits of the ALU result)
//   TIMEOUT - cycles to wait for memAck before aborting an access
//             (only meaningful when MEM_TIMEOUT_EN is defined)
//
// Build option:
//   MEM_TIMEOUT_EN - when defined, an access that sees no memAck within
//                    TIMEOUT cycles is aborted (load returns 0, store is
//                    dropped), the FSM carries on, and memErr latches high
//                    until reset. When undefined the unit waits forever and
//                    memErr is tied low.
// ---------------------------------------------------------------------------
module memory_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    memory_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Bundle held for the duration of its memory phase and writeback
    logic [31:0] alu1_p1;
    logic [31:0] alu2_p1;
    logic [31:0] sdata1_p1;
    logic [31:0] sdata2_p1;
    logic [31:0] ldata1_p1;
    logic [31:0] ldata2_p1;
    logic        ld1_p1;
    logic        ld2_p1;
    logic        we1_p1;
    logic        we2_p1;
    logic        wen1_p1;
    logic        wen2_p1;
    logic        mem2_p1;
    logic [3:0]  rd1_p1;
    logic [3:0]  rd2_p1;
    logic        redirect_p1;
    logic [31:0] redirect_pc_p1;

    logic accept;
    logic in_lane;
    logic in_live2;
    logic in_mem1;
    logic in_mem2;
    logic op_abort;
    logic op_done;

    assign in_lane  = (state == LANE1) || (state == LANE2);
    assign accept   = bus.inValid && !in_lane;

    // Lane 2 only exists architecturally if lane 1 did not branch away
    assign in_live2 = !bus.isBranchTaken1;
    assign in_mem1  = bus.isLd1 || bus.isSt1;
    assign in_mem2  = in_live2 && (bus.isLd2 || bus.isSt2);

    // An access finishes either by acknowledgement or by timeout abort
    assign op_done  = in_lane && (bus.memAck || op_abort);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             mem_err;

    // Abort on the edge that closes the TIMEOUT-th request cycle without ack
    assign op_abort = in_lane && !bus.memAck &&
                      (wait_cnt == CNT_W'(TIMEOUT - 1));

    // Counter restarts with every new request (each LANE1/LANE2 entry)
    always_ff @(posedge clk) begin
        if (rst || !in_lane || op_done) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (op_abort) begin
            mem_err <= 1'b1;
        end
    end

    assign bus.memErr = mem_err;
`else
    assign op_abort   = 1'b0;
    assign bus.memErr = 1'b0;
`endif

    // Load data returned for an access: zero when the access was aborted
    function automatic logic [31:0] load_result(input logic        abort,
                                                input logic [31:0] rdata);
        return abort ? 32'd0 : rdata;
    endfunction

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and memory-port / writeback outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        bus.stall    = 1'b0;
        bus.memReq   = 1'b0;
        bus.memWe    = 1'b0;
        bus.memAddr  = '0;
        bus.memWdata = 32'd0;
        bus.wbValid  = 1'b0;
        bus.wbEn1    = 1'b0;
        bus.wbEn2    = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                // DONE falls back to IDLE unless a new bundle arrives, which
                // gives one bundle per cycle for bundles without memory ops
                if (accept) begin
                    if (in_mem1) begin
                        state_nxt = LANE1;
                    end else if (in_mem2) begin
                        state_nxt = LANE2;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
                if (state == DONE) begin
                    bus.wbValid = 1'b1;
                    bus.wbEn1   = wen1_p1;
                    bus.wbEn2   = wen2_p1;
                end
            end
            LANE1: begin
                bus.stall    = 1'b1;
                bus.memReq   = 1'b1;
                bus.memWe    = we1_p1;
                bus.memAddr  = alu1_p1[ADDR_W-1:0];
                bus.memWdata = sdata1_p1;
                if (op_done) begin
                    state_nxt = mem2_p1 ? LANE2 : DONE;
                end
            end
            LANE2: begin
                bus.stall    = 1'b1;
                bus.memReq   = 1'b1;
                bus.memWe    = we2_p1;
                bus.memAddr  = alu2_p1[ADDR_W-1:0];
                bus.memWdata = sdata2_p1;
                if (op_done) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bundle capture at accept, load-data capture at completion, redirect
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            alu1_p1        <= 32'd0;
            alu2_p1        <= 32'd0;
            sdata1_p1      <= 32'd0;
            sdata2_p1      <= 32'd0;
            ldata1_p1      <= 32'd0;
            ldata2_p1      <= 32'd0;
            ld1_p1         <= 1'b0;
            ld2_p1         <= 1'b0;
            we1_p1         <= 1'b0;
            we2_p1         <= 1'b0;
            wen1_p1        <= 1'b0;
            wen2_p1        <= 1'b0;
            mem2_p1        <= 1'b0;
            rd1_p1         <= 4'd0;
            rd2_p1         <= 4'd0;
            redirect_p1    <= 1'b0;
            redirect_pc_p1 <= 32'd0;
        end else begin
            redirect_p1 <= accept && (bus.isBranchTaken1 || bus.isBranchTaken2);
            if (accept) begin
                alu1_p1        <= bus.aluResult1;
                alu2_p1        <= bus.aluResult2;
                sdata1_p1      <= bus.storeData1;
                sdata2_p1      <= bus.storeData2;
                ld1_p1         <= bus.isLd1;
                ld2_p1         <= bus.isLd2;
                // load wins when both load and store are flagged
                we1_p1         <= bus.isSt1 && !bus.isLd1;
                we2_p1         <= bus.isSt2 && !bus.isLd2;
                wen1_p1        <= bus.isWb1 && !bus.isSt1;
                wen2_p1        <= in_live2 && bus.isWb2 && !bus.isSt2;
                mem2_p1        <= in_mem2;
                rd1_p1         <= bus.rd1;
                rd2_p1         <= bus.rd2;
                redirect_pc_p1 <= bus.isBranchTaken1 ? bus.branchPC1 : bus.branchPC2;
            end
            if (state == LANE1 && op_done && ld1_p1) begin
                ldata1_p1 <= load_result(op_abort, bus.memRdata);
            end
            if (state == LANE2 && op_done && ld2_p1) begin
                ldata2_p1 <= load_result(op_abort, bus.memRdata);
            end
        end
    end

    assign bus.wbRd1      = rd1_p1;
    assign bus.wbRd2      = rd2_p1;
    assign bus.wbData1    = ld1_p1 ? ldata1_p1 : alu1_p1;
    assign bus.wbData2    = ld2_p1 ? ldata2_p1 : alu2_p1;
    assign bus.redirect   = redirect_p1;
    assign bus.redirectPC = redirect_pc_p1;

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Dual-lane memory stage directly downstream of the dual-issue execute unit.
- Accepts one two-instruction bundle per cycle: ALU results, store data, branch outcomes and writeback tags.
- Performs that bundle's loads and stores serially over a single req/ack data-memory port, then hands a writeback bundle to the register-file write stage.
- Also issues the registered fetch redirect and squashes lane 2 when lane 1's branch is taken.

Parameters:
- ADDR_W, 32, data-memory address width (low ADDR_W bits of aluResult).
- TIMEOUT, 16, max cycles to wait for memAck; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- inValid  in  1  bundle from execute is valid
- aluResult1/aluResult2  in  32  ALU result; address for load/store
- storeData1/storeData2  in  32  store data (execute opB)
- isLd1/isLd2  in  1  lane is a load
- isSt1/isSt2  in  1  lane is a store
- isWb1/isWb2  in  1  lane writes a register
- rd1/rd2  in  4  destination register
- isBranchTaken1/isBranchTaken2  in  1  branch outcome from execute
- branchPC1/branchPC2  in  32  branch/return target
- stall  out  1  upstream must hold its bundle
- memReq  out  1  memory request
- memWe  out  1  1 = store, 0 = load
- memAddr  out  ADDR_W  request address
- memWdata  out  32  store data
- memRdata  in  32  load data, valid with memAck
- memAck  in  1  request completed
- wbValid  out  1  writeback bundle valid (one cycle)
- wbEn1/wbEn2  out  1  register write enable per lane
- wbRd1/wbRd2  out  4  destination register
- wbData1/wbData2  out  32  load data or ALU result
- redirect  out  1  one-cycle fetch redirect pulse
- redirectPC  out  32  redirect target
- memErr  out  1  timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- States: IDLE, LANE1, LANE2, DONE (registered).
- stall = (state == LANE1 || state == LANE2). A bundle is accepted on an edge where inValid && !stall, i.e. in IDLE or DONE.
- Lane 2 is live only if !isBranchTaken1; a squashed lane 2 performs no memory op and has wbEn2 = 0.
- A lane with both isLd and isSt set is treated as a load.
- Lane mem op = isLd || isSt (lane 2 also requires lane 2 live).
- Accept transition:
  - lane 1 has a mem op -> LANE1
  - else lane 2 has a mem op -> LANE2
  - else -> DONE
- With no accept, DONE -> IDLE and IDLE holds.
- LANE1 / LANE2 drive memReq = 1 combinationally from state, with memAddr, memWe and memWdata of that lane; these are held stable until memAck.
- On an edge with memAck = 1:
  - a load captures memRdata into that lane's result
  - LANE1 goes to LANE2 if lane 2 has a mem op, else DONE
  - LANE2 goes to DONE
- memAck outside LANE1/LANE2 is ignored. At most one request is outstanding.
- DONE outputs:
  - wbValid = 1
  - wbDataN = captured load data for loads, else aluResultN
  - wbEnN = isWbN && !isStN (lane 2 also requires lane 2 live)
- Latency:
  - no-mem bundle: wbValid one cycle after accept; back-to-back throughput of one bundle per cycle (DONE -> DONE)
  - memory bundle: wbValid one cycle after the final memAck
- Redirect:
  - registered at accept, asserted for exactly the following cycle, independent of memory ops
  - redirect = isBranchTaken1 || isBranchTaken2
  - redirectPC = branchPC1 if isBranchTaken1, else branchPC2
- Reset: state = IDLE; stall, memReq, wbValid, wbEn1/2, redirect and memErr = 0; all data registers = 0.
  - Reset mid-transaction drops memReq on the next cycle and discards the bundle.
  - A late ack after reset is ignored.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - a cycle counter runs in LANE1/LANE2 and clears on each new request
  - if TIMEOUT cycles pass without memAck, the op aborts: load result = 0, the store is dropped, and the FSM advances as if acked
  - memErr is held high until reset
- MEM_TIMEOUT_EN undefined: no counter, the FSM waits indefinitely, memErr = 0.

Test Plan:
- ALU-only bundle, aluResult1 = 0x15, aluResult2 = 0x1D, isWb1/2 = 1, rd1 = 3, rd2 = 4 -> one cycle later: wbValid = 1, wbData1 = 0x15, wbData2 = 0x1D, stall stays 0.
- Lane 1 load from 0x40, memAck after 3 cycles with memRdata = 0xDEADBEEF -> stall high 3 cycles, memReq/memAddr = 0x40 held, wbData1 = 0xDEADBEEF one cycle after ack.
- Lane 1 store 0x10 -> 0x80 and lane 2 load from 0x84 (ack 0x1234) -> two sequential requests (memWe 1 then 0), wbEn1 = 0, wbData2 = 0x1234.
- isBranchTaken1 = 1, branchPC1 = 0x8, lane 2 is a store -> redirect pulse with redirectPC = 0x8, no memory request for lane 2, wbEn2 = 0.
- rst asserted in LANE1 before ack -> memReq 0 next cycle, wbValid never asserted, subsequent memAck ignored.
- (MEM_TIMEOUT_EN, TIMEOUT = 16) load never acked -> after 16 cycles memErr = 1, wbData1 = 0, wbValid pulses.
